// File: rtl/nl_lights_pkg.sv
// Shared types and default parameter values for the night-light sensor front-end.
package nl_lights_pkg;

  localparam int unsigned LIGHT_W             = 8;
  localparam int unsigned DARK_ON_LVL_DEF     = 40;
  localparam int unsigned DARK_OFF_LVL_DEF    = 60;
  localparam int unsigned HOLD_CYCLES_DEF     = 16;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } debounce_state_t;

endpackage

// File: rtl/nl_lights_sensor_frontend_if.sv
// Raw sensor inputs and conditioned control bits of the sensor front-end.
interface nl_lights_sensor_frontend_if;
  import nl_lights_pkg::*;

  logic               light_val;
  logic [LIGHT_W-1:0] light_lvl;
  logic               pir;
  logic               button;
  logic               dark;
  logic               movement;
  logic               force_on;

  modport master (
    output light_val, light_lvl, pir, button,
    input  dark, movement, force_on
  );

  modport slave (
    input  light_val, light_lvl, pir, button,
    output dark, movement, force_on
  );

endinterface

// File: rtl/nl_lights_debounce.sv
// Push-button synchronizer and debounce FSM producing a toggling manual override.
module nl_lights_debounce
  import nl_lights_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_button,
  output logic o_force_on
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_bs;
  debounce_state_t r_state;
  debounce_state_t w_state_nx;
  logic [DB_W-1:0] r_db_cnt;
  logic [DB_W-1:0] w_db_cnt_nx;
  logic            w_toggle;
  logic            r_force_on;

  // State, counter, synchronizer and override registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_bs       <= 1'b0;
      r_state    <= IDLE;
      r_db_cnt   <= '0;
      r_force_on <= 1'b0;
    end else begin
      r_sync1    <= i_button;
      r_bs       <= r_sync1;
      r_state    <= w_state_nx;
      r_db_cnt   <= w_db_cnt_nx;
      r_force_on <= r_force_on ^ w_toggle;
    end
  end

  // Next state: a press or release must be stable for DEBOUNCE_CYCLES samples
  always_comb begin
    w_state_nx  = r_state;
    w_db_cnt_nx = r_db_cnt;
    w_toggle    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_bs) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nx = HELD;
            w_toggle   = 1'b1;
          end else begin
            w_state_nx  = PRESS_WAIT;
            w_db_cnt_nx = DB_W'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!r_bs) begin
          w_state_nx = IDLE;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nx = HELD;
          w_toggle   = 1'b1;
        end else begin
          w_db_cnt_nx = r_db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        if (!r_bs) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nx = IDLE;
          end else begin
            w_state_nx  = RELEASE_WAIT;
            w_db_cnt_nx = DB_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (r_bs) begin
          w_state_nx = HELD;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nx = IDLE;
        end else begin
          w_db_cnt_nx = r_db_cnt + DB_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign o_force_on = r_force_on;

endmodule

// File: rtl/nl_lights_sensor_frontend.sv
// Night-light sensor front-end: light hysteresis, PIR hold stretcher and button override.
module nl_lights_sensor_frontend
  import nl_lights_pkg::*;
#(
  parameter int unsigned DARK_ON_LVL     = DARK_ON_LVL_DEF,
  parameter int unsigned DARK_OFF_LVL    = DARK_OFF_LVL_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic                        clk,
  input logic                        reset,
  nl_lights_sensor_frontend_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic              r_dark;
  logic              w_dark_nx;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nx;
  logic              r_movement;
  logic              w_force_on;

  // Hysteresis on valid light samples; levels between thresholds hold the flag
  always_comb begin
    w_dark_nx = r_dark;
    if (bus.light_val) begin
      if (bus.light_lvl <= LIGHT_W'(DARK_ON_LVL)) begin
        w_dark_nx = 1'b1;
      end else if (bus.light_lvl >= LIGHT_W'(DARK_OFF_LVL)) begin
        w_dark_nx = 1'b0;
      end
    end
  end

  // Retriggerable hold: PIR reloads, otherwise count down to zero and stop
  always_comb begin
    w_hold_nx = r_hold_cnt;
    if (bus.pir) begin
      w_hold_nx = HOLD_W'(HOLD_CYCLES);
    end else if (r_hold_cnt != '0) begin
      w_hold_nx = r_hold_cnt - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dark     <= 1'b0;
      r_hold_cnt <= '0;
      r_movement <= 1'b0;
    end else begin
      r_dark     <= w_dark_nx;
      r_hold_cnt <= w_hold_nx;
      r_movement <= (w_hold_nx != '0);
    end
  end

  nl_lights_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .i_button  (bus.button),
    .o_force_on(w_force_on)
  );

  assign bus.dark     = r_dark;
  assign bus.movement = r_movement;
  assign bus.force_on = w_force_on;

endmodule

// File: doc/nl_lights_sensor_frontend.md
# nl_lights_sensor_frontend

Sensor front-end for the night-light controller: conditions raw sensor inputs into the three clean control bits (`dark`, `movement`, `force_on`) that the lights combinational logic consumes. Applies hysteresis to an 8-bit ambient-light sample stream, stretches PIR motion pulses with a retriggerable hold timer, and debounces a wall push-button into a toggling manual override. All outputs are registered.

## Interface
- `DARK_ON_LVL`, default 40: light level at or below which `dark` sets.
- `DARK_OFF_LVL`, default 60: light level at or above which `dark` clears; must be greater than `DARK_ON_LVL`.
- `HOLD_CYCLES`, default 16: cycles `movement` stays high after the last PIR-high cycle; must be ≥1.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a button edge; must be ≥1.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `light_val` in 1: `light_lvl` carries a valid sample this cycle.
- `light_lvl` in 8: unsigned ambient-light sample (0 = darkest).
- `pir` in 1: raw PIR detector output, synchronous to `clk`.
- `button` in 1: raw asynchronous push-button (1 = pressed).
- `dark` out 1: registered ambient-dark flag.
- `movement` out 1: registered stretched-motion flag.
- `force_on` out 1: registered manual-override toggle.

## Operation
- Reset (async, immediate): `dark`=0, `movement`=0, `force_on`=0; hold counter=0; debounce FSM=IDLE, debounce counter=0; both synchronizer flops=0.
- Dark hysteresis: evaluated only when `light_val`=1.
  - `light_lvl` ≤ `DARK_ON_LVL` → `dark`←1.
  - `light_lvl` ≥ `DARK_OFF_LVL` → `dark`←0.
  - Otherwise hold. When `light_val`=0, `light_lvl` is ignored.
- Movement hold: `hold_cnt` is `$clog2(HOLD_CYCLES+1)` bits.
  - `pir`=1 → `hold_cnt`←`HOLD_CYCLES` (retrigger, no accumulation).
  - Else if `hold_cnt`≠0 → decrement. It never wraps below 0.
  - `movement`←(next `hold_cnt`≠0).
- Button path: two-flop synchronizer produces `b_s`, then a debounce FSM with counter `db_cnt`.
  - IDLE: `b_s`=1 → PRESS_WAIT, `db_cnt`=1 (or straight to HELD with toggle if `DEBOUNCE_CYCLES`=1).
  - PRESS_WAIT: `b_s`=0 → IDLE. `b_s`=1 with `db_cnt`=`DEBOUNCE_CYCLES`−1 → HELD and `force_on`←~`force_on`. Otherwise `db_cnt`++.
  - HELD: `b_s`=0 → RELEASE_WAIT, `db_cnt`=1 (or straight to IDLE if `DEBOUNCE_CYCLES`=1).
  - RELEASE_WAIT: `b_s`=1 → HELD (no toggle). `b_s`=0 with `db_cnt`=`DEBOUNCE_CYCLES`−1 → IDLE. Otherwise `db_cnt`++.
  - Exactly one toggle per accepted press. Release never toggles.

## Timing
- `dark`: updates the cycle after the qualifying `light_val` cycle.
- `movement`: PIR high in cycle t (single cycle) → `movement` high in cycles t+1 … t+`HOLD_CYCLES`, low at t+`HOLD_CYCLES`+1. PIR held high continuously keeps `movement` high.
- `force_on`: `button` rises before edge t and stays high → `b_s` high from cycle t+2 → `force_on` toggles visible at cycle t+`DEBOUNCE_CYCLES`+2 (t+6 at default).
- A bounce that returns `b_s` to 0 before `DEBOUNCE_CYCLES` consecutive samples produces no toggle.
- Simultaneous events are independent: all three paths update in the same cycle.
- `reset` asserted mid-hold or mid-debounce clears everything immediately. First activity after release is evaluated from the reset state.

## Structure
- Package `nl_lights_pkg`:
  - `debounce_state_t` enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - Default constants for the four parameters.
- Sub-module `nl_lights_debounce`: synchronizer, FSM and toggle register; outputs `force_on`. Hysteresis and hold timer stay inline in the top.

## Test plan
- Reset, then `light_val`=1 with levels 100, 50, 40, 50, 60 → `dark` = 0, 0, 1, 1, 0, each visible one cycle after its sample; `light_val`=0 with level 0 → `dark` unchanged.
- `pir` pulse 1 cycle at t → `movement` high exactly cycles t+1..t+16; retrigger at t+10 → high through t+26.
- `button` held high from t → `force_on` 0→1 at t+6; release then press again → back to 0 at t+6 after the second press.
- `button` glitches high for 3 cycles (`b_s`), then low → `force_on` never toggles; release bounce of 2 low cycles while held → no extra toggle.
- `reset` asserted at t+5 of a hold and mid-PRESS_WAIT → `movement`, `force_on`, `dark` read 0 at once; a new press after reset toggles `force_on` 0→1 with full latency.
- Simultaneous `light_val` (level 10), `pir`=1 and a qualified press → all three outputs update per their individual latencies, with no interaction.
